// File: rtl/branch_resolver.sv
// Branch resolver: evaluates a captured branch request against the ALU flag register
// and produces the next PC, link write and a two-cycle flush for taken branches.
module branch_resolver (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flag_we,
    input  logic        carry_we,
    input  logic        sign_in,
    input  logic        zero_in,
    input  logic        carry_in,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic [3:0]  br_op,
    input  logic [31:0] pc,
    input  logic [31:0] offset,
    input  logic [31:0] reg_target,
    output logic        out_valid,
    output logic        taken,
    output logic [31:0] target,
    output logic        link_we,
    output logic [31:0] link,
    output logic        illegal,
    output logic        flush,
    output logic        sign_q,
    output logic        zero_q,
    output logic        carry_q,
    output logic [15:0] taken_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        FLUSH1 = 2'd2,
        FLUSH2 = 2'd3
    } state_t;

    state_t      state_q;
    logic        outValid_q;
    logic        taken_q;
    logic [31:0] target_q;
    logic        linkWe_q;
    logic [31:0] link_q;
    logic        illegal_q;
    logic [15:0] takenCnt_q;

    logic        sign_d;
    logic        zero_d;
    logic        carry_d;
    logic        condTaken;
    logic        legalOp;
    logic        useReg;
    logic        isCall;
    logic [31:0] pcPlus4;
    logic [31:0] branchTarget;
    logic [31:0] target_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q  <= 1'b0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            if (flag_we) begin
                sign_q <= sign_in;
                zero_q <= zero_in;
            end
            if (carry_we) begin
                carry_q <= carry_in;
            end
        end
    end

    // The decision is taken on the capture edge from the flag values being written on
    // that same edge, so it reflects them in EVAL and ignores writes made during EVAL.
    always_comb begin
        sign_d       = flag_we  ? sign_in  : sign_q;
        zero_d       = flag_we  ? zero_in  : zero_q;
        carry_d      = carry_we ? carry_in : carry_q;
        pcPlus4      = pc + 32'd4;
        branchTarget = pc + offset;
        condTaken    = 1'b0;
        legalOp      = 1'b1;
        useReg       = 1'b0;
        isCall       = 1'b0;
        case (br_op)
            4'b0000: condTaken = 1'b1;
            4'b0001: condTaken = sign_d;
            4'b0010: condTaken = zero_d;
            4'b0011: condTaken = !zero_d;
            4'b0100: condTaken = carry_d;
            4'b0101: condTaken = !carry_d;
            4'b0110: begin condTaken = 1'b1; useReg = 1'b1; end
            4'b0111: begin condTaken = 1'b1; isCall = 1'b1; end
            4'b1000: begin condTaken = 1'b1; useReg = 1'b1; end
            default: legalOp = 1'b0;
        endcase
        if (!condTaken) begin
            target_d = pcPlus4;
        end else if (useReg) begin
            target_d = reg_target;
        end else begin
            target_d = branchTarget;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            outValid_q <= 1'b0;
            taken_q    <= 1'b0;
            target_q   <= 32'd0;
            linkWe_q   <= 1'b0;
            link_q     <= 32'd0;
            illegal_q  <= 1'b0;
            takenCnt_q <= 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (br_valid) begin
                        outValid_q <= 1'b1;
                        taken_q    <= condTaken;
                        target_q   <= target_d;
                        linkWe_q   <= isCall;
                        link_q     <= pcPlus4;
                        illegal_q  <= !legalOp;
                        state_q    <= EVAL;
                    end
                end
                EVAL: begin
                    outValid_q <= 1'b0;
                    taken_q    <= 1'b0;
                    linkWe_q   <= 1'b0;
                    illegal_q  <= 1'b0;
                    if (taken_q) begin
                        if (takenCnt_q != 16'hFFFF) begin
                            takenCnt_q <= takenCnt_q + 16'd1;
                        end
                        state_q <= FLUSH1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                FLUSH1:  state_q <= FLUSH2;
                FLUSH2:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign br_ready  = (state_q == IDLE);
    assign flush     = (state_q == FLUSH1) || (state_q == FLUSH2);
    assign out_valid = outValid_q;
    assign taken     = taken_q;
    assign target    = target_q;
    assign link_we   = linkWe_q;
    assign link      = link_q;
    assign illegal   = illegal_q;
    assign taken_cnt = takenCnt_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed cases plus randomized branches
// compared against a rule-level reference model of flags, targets and the taken count.
module tb_branch_resolver;

    logic        clk;
    logic        rst_n;
    logic        flag_we;
    logic        carry_we;
    logic        sign_in;
    logic        zero_in;
    logic        carry_in;
    logic        br_valid;
    logic        br_ready;
    logic [3:0]  br_op;
    logic [31:0] pc;
    logic [31:0] offset;
    logic [31:0] reg_target;
    logic        out_valid;
    logic        taken;
    logic [31:0] target;
    logic        link_we;
    logic [31:0] link;
    logic        illegal;
    logic        flush;
    logic        sign_q;
    logic        zero_q;
    logic        carry_q;
    logic [15:0] taken_cnt;

    int checkCount = 0;
    int passCount  = 0;

    logic        mSign;
    logic        mZero;
    logic        mCarry;
    int          mCnt;
    logic [31:0] mTarget;
    logic [31:0] mLink;

    branch_resolver dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flag_we    (flag_we),
        .carry_we   (carry_we),
        .sign_in    (sign_in),
        .zero_in    (zero_in),
        .carry_in   (carry_in),
        .br_valid   (br_valid),
        .br_ready   (br_ready),
        .br_op      (br_op),
        .pc         (pc),
        .offset     (offset),
        .reg_target (reg_target),
        .out_valid  (out_valid),
        .taken      (taken),
        .target     (target),
        .link_we    (link_we),
        .link       (link),
        .illegal    (illegal),
        .flush      (flush),
        .sign_q     (sign_q),
        .zero_q     (zero_q),
        .carry_q    (carry_q),
        .taken_cnt  (taken_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h at %0t", tag, observed, expected, $time);
        end else begin
            passCount++;
        end
    endtask

    function automatic logic refTaken(input logic [3:0] op, input logic s, input logic z, input logic c);
        case (op)
            4'd0:    return 1'b1;
            4'd1:    return s;
            4'd2:    return z;
            4'd3:    return !z;
            4'd4:    return c;
            4'd5:    return !c;
            4'd6, 4'd7, 4'd8: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Advance one cycle; the model sees exactly the flag writes the DUT sampled.
    task automatic stepClock();
        @(posedge clk);
        if (rst_n) begin
            if (flag_we) begin
                mSign = sign_in;
                mZero = zero_in;
            end
            if (carry_we) mCarry = carry_in;
        end
        @(negedge clk);
    endtask

    task automatic setFlags(input logic [4:0] f);
        {flag_we, carry_we, sign_in, zero_in, carry_in} = f;
    endtask

    task automatic driveNoise();
        br_valid   = 1'($urandom_range(0, 1));
        br_op      = 4'($urandom_range(0, 15));
        pc         = $urandom;
        offset     = $urandom;
        reg_target = $urandom;
        setFlags(5'($urandom_range(0, 31)));
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_ready"}, br_ready, 1);
        checkOutput({tag, "_flush"}, flush, 0);
        checkOutput({tag, "_vld"}, out_valid, 0);
        checkOutput({tag, "_taken"}, taken, 0);
        checkOutput({tag, "_lwe"}, link_we, 0);
        checkOutput({tag, "_ill"}, illegal, 0);
        checkOutput({tag, "_tgt"}, target, mTarget);
        checkOutput({tag, "_link"}, link, mLink);
        checkOutput({tag, "_cnt"}, taken_cnt, 32'(mCnt));
        checkOutput({tag, "_flags"}, {sign_q, zero_q, carry_q}, {mSign, mZero, mCarry});
    endtask

    // One full branch from an IDLE negedge back to the next IDLE negedge.
    // Flag vectors are {flag_we, carry_we, sign_in, zero_in, carry_in}.
    task automatic applyStimulus(input string tag, input logic [3:0] op, input logic [31:0] pcV,
                                 input logic [31:0] offV, input logic [31:0] regV,
                                 input logic [4:0] capFlags, input logic [4:0] evalFlags);
        logic        expTaken;
        logic [31:0] expTarget;
        checkOutput({tag, "_ready_in"}, br_ready, 1);
        br_valid   = 1'b1;
        br_op      = op;
        pc         = pcV;
        offset     = offV;
        reg_target = regV;
        setFlags(capFlags);
        stepClock();
        expTaken = refTaken(op, mSign, mZero, mCarry);
        if (!expTaken)                      expTarget = pcV + 32'd4;
        else if (op == 4'd6 || op == 4'd8)  expTarget = regV;
        else                                expTarget = pcV + offV;
        mTarget = expTarget;
        mLink   = pcV + 32'd4;
        driveNoise();
        setFlags(evalFlags);
        checkOutput({tag, "_vld"}, out_valid, 1);
        checkOutput({tag, "_taken"}, taken, 32'(expTaken));
        checkOutput({tag, "_tgt"}, target, expTarget);
        checkOutput({tag, "_link"}, link, mLink);
        checkOutput({tag, "_lwe"}, link_we, 32'(op == 4'd7));
        checkOutput({tag, "_ill"}, illegal, 32'(op > 4'd8));
        checkOutput({tag, "_busy"}, br_ready, 0);
        checkOutput({tag, "_noflush"}, flush, 0);
        stepClock();
        if (expTaken) begin
            if (mCnt < 65535) mCnt = mCnt + 1;
            for (int k = 0; k < 2; k++) begin
                checkOutput({tag, "_flush"}, flush, 1);
                checkOutput({tag, "_fvld"}, out_valid, 0);
                checkOutput({tag, "_fbusy"}, br_ready, 0);
                checkOutput({tag, "_fhold"}, target, mTarget);
                driveNoise();
                stepClock();
            end
        end
        br_valid = 1'b0;
        setFlags(5'b0);
        checkIdle({tag, "_end"});
    endtask

    task automatic resetMidway(input string tag, input int cyclesAfterCapture);
        br_valid   = 1'b1;
        br_op      = 4'd0;
        pc         = 32'h300;
        offset     = 32'h40;
        reg_target = 32'h0;
        setFlags(5'b11111);
        stepClock();
        br_valid = 1'b0;
        setFlags(5'b0);
        for (int k = 1; k < cyclesAfterCapture; k++) stepClock();
        rst_n = 1'b0;
        mSign = 0; mZero = 0; mCarry = 0; mCnt = 0; mTarget = 0; mLink = 0;
        #1;
        checkIdle({tag, "_rst"});
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checkIdle({tag, "_post"});
            stepClock();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        br_valid = 1'b0; br_op = 4'd0; pc = 32'd0; offset = 32'd0; reg_target = 32'd0;
        setFlags(5'b0);
        mSign = 0; mZero = 0; mCarry = 0; mCnt = 0; mTarget = 0; mLink = 0;
        #3;
        checkIdle("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checkIdle("release");

        applyStimulus("bz_taken", 4'b0010, 32'h100, 32'h20, 32'h0, 5'b10010, 5'b0);
        applyStimulus("bcy_not", 4'b0100, 32'h200, 32'h40, 32'h0, 5'b01000, 5'b0);
        applyStimulus("call_wrap", 4'b0111, 32'hFFFF_FFFC, 32'h8, 32'h0, 5'b0, 5'b0);
        checkOutput("call_wrap_link0", link, 32'h0);
        applyStimulus("bltz_cap", 4'b0001, 32'h400, 32'h10, 32'h0, 5'b10100, 5'b10000);
        applyStimulus("bnz_clr", 4'b0011, 32'h500, 32'hFFFF_FFF0, 32'h0, 5'b10010, 5'b10000);
        applyStimulus("bncy", 4'b0101, 32'h600, 32'h80, 32'h0, 5'b01000, 5'b01001);
        applyStimulus("breg", 4'b0110, 32'h700, 32'h10, 32'h0000_1234, 5'b0, 5'b0);
        applyStimulus("ret", 4'b1000, 32'h800, 32'h10, 32'hDEAD_BEE0, 5'b0, 5'b0);
        applyStimulus("illegal", 4'b1010, 32'h900, 32'h10, 32'h0, 5'b0, 5'b0);
        applyStimulus("ill_wrap", 4'b1111, 32'hFFFF_FFFE, 32'h10, 32'h0, 5'b0, 5'b0);

        // Preload the counter near its ceiling rather than issuing 65k branches.
        force dut.takenCnt_q = 16'hFFFE;
        stepClock();
        release dut.takenCnt_q;
        mCnt = 65534;
        checkOutput("cnt_preload", taken_cnt, 32'hFFFE);
        applyStimulus("sat_a", 4'b0000, 32'h1000, 32'h4, 32'h0, 5'b0, 5'b0);
        applyStimulus("sat_b", 4'b0000, 32'h2000, 32'h4, 32'h0, 5'b0, 5'b0);
        checkOutput("cnt_sat", taken_cnt, 32'hFFFF);

        resetMidway("rst_flush1", 2);
        resetMidway("rst_eval", 1);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] pcR;
            int gap;
            pcR = (i % 10 == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            applyStimulus("rand", 4'($urandom_range(0, 15)), pcR, $urandom, $urandom,
                          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                br_valid = 1'b0;
                setFlags(5'($urandom_range(0, 31)));
                stepClock();
                setFlags(5'b0);
                checkIdle("gap");
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
